pe_fpbp_feeder: RTL

- Transmit-side sequencer that drives one FPBP processing element: i0/i1 activations, w0/w1/w2 weights, select0/select1 lane routing.
- Accepts a weight triple and a ready/valid activation stream, schedules the PE lanes, then flushes the PE pipeline with zeros.
- Emits a result-valid tag aligned to the PE psum outputs so downstream logic knows when out0..out2 are meaningful.
- Sits between the activation buffer and the PE, one instance per PE row.

---
 rtl/pe_fpbp_feeder_pkg.sv | 35 +++
 rtl/pe_fpbp_feeder_tag_delay.sv | 47 ++++
 rtl/pe_fpbp_feeder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pe_fpbp_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_fpbp_feeder_pkg
// Description : Shared definitions for the FPBP PE feeder. This file holds the
//               sequencer state encoding, the lane-mode encoding, and a helper
//               that maps a lane mode to the PE select pair.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_fpbp_feeder_pkg;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADW  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Lane-routing modes
    localparam logic MODE_BCAST = 1'b0;  // every lane takes i0
    localparam logic MODE_DUAL  = 1'b1;  // lane1 takes i1, lane2 takes delayed i0

    // Select pair {select0, select1} for a given mode
    function automatic logic [1:0] mode_selects(input logic mode);
        logic [1:0] sel;
        sel = 2'b00;
        if (mode == MODE_DUAL) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_fpbp_feeder_tag_delay.sv
`default_nettype none
// ============================================================================
// Module      : pe_tag_delay
// Description : This module is a LAT-deep 1-bit shift register. It delays the
//               "real sample" tag so that the tag lines up with the PE psum
//               outputs.
// Ports       : clk     - clock
//               reset   - asynchronous active-high reset, clears every stage
//               tag_in  - tag aligned with the PE activation inputs
//               tag_out - the tag delayed by LAT cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pe_tag_delay #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tag_in,
    output logic tag_out
);

    logic [LAT-1:0] r_sr;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= tag_in;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[LAT-2:0], tag_in};
                end
            end
        end
    endgenerate

    assign tag_out = r_sr[LAT-1];

endmodule
`default_nettype wire

// File: rtl/pe_fpbp_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_fpbp_feeder
// Description : Transmit-side sequencer for a single FPBP processing element.
//               It latches a weight triple and a lane mode. It streams a
//               ready/valid activation sequence onto i0/i1. It then flushes
//               the PE pipeline with zeros. A result-valid tag is produced
//               that is aligned with the PE psum outputs.
// Ports       : clk, reset           - clock, asynchronous active-high reset
//               start, mode          - job launch pulse and lane mode (IDLE only)
//               cfg_len              - samples per job (0 allowed)
//               cfg_w0..cfg_w2       - weights, latched with start
//               s_valid/s_data/s_ready - activation stream handshake
//               i0, i1               - PE activation inputs
//               w0..w2               - PE weight inputs
//               select0, select1     - PE lane-routing selects
//               res_valid            - PE psum outputs hold a real sample
//               busy, done           - job in progress / one-cycle end pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pe_fpbp_feeder
    import pe_fpbp_feeder_pkg::*;
#(
    parameter int N     = 8,
    parameter int LEN_W = 8,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [N-1:0]     cfg_w0,
    input  logic [N-1:0]     cfg_w1,
    input  logic [N-1:0]     cfg_w2,
    input  logic             s_valid,
    input  logic [N-1:0]     s_data,
    output logic             s_ready,
    output logic [N-1:0]     i0,
    output logic [N-1:0]     i1,
    output logic [N-1:0]     w0,
    output logic [N-1:0]     w1,
    output logic [N-1:0]     w2,
    output logic             select0,
    output logic             select1,
    output logic             res_valid,
    output logic             busy,
    output logic             done
);

    localparam int                c_flush_w    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(LAT - 1);
    localparam logic [LEN_W-1:0]  c_len_one    = LEN_W'(1);

    state_t               r_state;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_count;
    logic [c_flush_w-1:0] r_flush;
    logic [N-1:0]         r_prev;
    logic [N-1:0]         r_i0;
    logic [N-1:0]         r_i1;
    logic [N-1:0]         r_w0;
    logic [N-1:0]         r_w1;
    logic [N-1:0]         r_w2;
    logic                 r_sel0;
    logic                 r_sel1;
    logic                 r_s_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_tag;
    logic                 w_hs;
    logic [1:0]           w_sel;

    // r_s_ready is high only in STREAM, so this handshake can only occur there
    assign w_hs  = s_valid & r_s_ready;
    assign w_sel = mode_selects(mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_flush   <= '0;
            r_prev    <= '0;
            r_i0      <= '0;
            r_i1      <= '0;
            r_w0      <= '0;
            r_w1      <= '0;
            r_w2      <= '0;
            r_sel0    <= 1'b0;
            r_sel1    <= 1'b0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tag     <= 1'b0;
        end else begin
            // Activations and tag default to a zero bubble every cycle
            r_i0   <= '0;
            r_i1   <= '0;
            r_tag  <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Weights and selects are loaded here, so they are
                        // visible during LOADW. They then hold until the next
                        // job is accepted.
                        r_len   <= cfg_len;
                        r_w0    <= cfg_w0;
                        r_w1    <= cfg_w1;
                        r_w2    <= cfg_w2;
                        r_sel0  <= w_sel[1];
                        r_sel1  <= w_sel[0];
                        r_busy  <= 1'b1;
                        r_state <= ST_LOADW;
                    end
                end

                ST_LOADW: begin
                    r_count <= '0;
                    r_flush <= '0;
                    r_prev  <= '0;
                    if (r_len == '0) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_s_ready <= 1'b1;
                        r_state   <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (w_hs) begin
                        r_i0    <= s_data;
                        r_i1    <= r_prev;
                        r_prev  <= s_data;
                        r_tag   <= 1'b1;
                        r_count <= r_count + c_len_one;
                        // The compare runs before the increment, so the count
                        // never has to represent a value above cfg_len.
                        if (r_count == r_len - c_len_one) begin
                            r_s_ready <= 1'b0;
                            r_state   <= ST_FLUSH;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (r_flush == c_flush_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_flush <= r_flush + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // r_tag is aligned with r_i0, so a LAT-deep delay brings it into line
    // with the psum outputs.
    pe_tag_delay #(
        .LAT (LAT)
    ) u_tag_delay (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (r_tag),
        .tag_out (res_valid)
    );

    assign s_ready = r_s_ready;
    assign i0      = r_i0;
    assign i1      = r_i1;
    assign w0      = r_w0;
    assign w1      = r_w1;
    assign w2      = r_w2;
    assign select0 = r_sel0;
    assign select1 = r_sel1;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire
